// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int          DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer: storage, read/write pointers and occupancy.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  fq_entry_t     push_entry,
    input  logic          pop,
    input  logic          flush,
    output fq_entry_t     head,
    output logic [CW-1:0] count
);

    fq_entry_t       mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            unique case (1'b1)
                flush: begin
                    wptr  <= '0;
                    rptr  <= '0;
                    count <= '0;
                end
                default: begin
                    if (push) wptr <= wptr + PW'(1);
                    if (pop)  rptr <= rptr + PW'(1);
                    count <= count + CW'(push) - CW'(pop);
                end
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// IF-stage prefetch: single outstanding imem request feeding fetch_fifo.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pcplus4
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          req_q;
    logic          disc_q;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;

    logic          ack;
    logic          hold;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic [31:0]   pc_nx;
    fq_entry_t     head;
    fq_entry_t     push_entry;
    logic          unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];

    always_comb begin
        ack      = req_q && imem_ack;
        hold     = req_q && !imem_ack;
        push     = ack && !disc_q && !redirect;
        pop      = id_valid && id_ready && !redirect;
        count_nx = redirect ? '0 : count + CW'(push) - CW'(pop);
        // Issue against next-cycle occupancy so a freed slot refills at once.
        issue    = !hold && (count_nx < FULL);
        pc_nx    = fetch_pc;
        unique case (1'b1)
            redirect: pc_nx = {redirect_pc[31:2], 2'b00};
            push:     pc_nx = fetch_pc + 32'd4;
            default:  pc_nx = fetch_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q    <= 1'b0;
            disc_q   <= 1'b0;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            fetch_pc <= pc_nx;
            if (!hold) begin
                req_q <= issue;
                if (issue) req_addr <= pc_nx;
            end
            if (ack) begin
                disc_q <= 1'b0;
            end else if (redirect && req_q) begin
                disc_q <= 1'b1;
            end
        end
    end

    assign push_entry.instr   = imem_data;
    assign push_entry.pcplus4 = req_addr + 32'd4;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

    assign imem_req   = req_q;
    assign imem_addr  = req_addr;
    assign id_valid   = (count != '0);
    assign id_instr   = id_valid ? head.instr : NOP;
    assign id_pcplus4 = id_valid ? head.pcplus4 : 32'd0;

endmodule
